machine_pattern_detect: RTL and testbench

Parametrised serial sequence detector: the successor to the fixed 3-bit hand-wired state machines. It detects a runtime-programmable N-bit pattern on serial input x. Selectable overlapping or non-overlapping detection. Adds clock enable, a saturating match counter and exposed state, and serves as the generic detector in later assignment designs.

---
 rtl/machine_pkg.sv | 26 ++
 rtl/machine_dff.sv | 22 ++
 rtl/machine_pd_history.sv | 44 ++++
 rtl/machine_pattern_detect.sv | 79 +++++++
 tb/tb_machine_pattern_detect.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/machine_pkg.sv
// rtl/machine_pkg.sv - shared helpers and parameter checks for the pattern detector

`ifndef MACHINE_PKG_SV
`define MACHINE_PKG_SV

// Stops elaboration when a parameter lies outside its legal range.
`define MACHINE_RANGE_CHECK(label, val, lo, hi) \
  if (((val) < (lo)) || ((val) > (hi))) begin : label \
    $error("machine: parameter value %0d outside legal range %0d..%0d", (val), (lo), (hi)); \
  end

package machine_pkg;

  // Width needed to hold a fill count of 0..n.
  function automatic int s_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Largest value held by a w-bit unsigned counter.
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

`endif

// File: rtl/machine_dff.sv
// rtl/machine_dff.sv - enabled register with asynchronous active-low reset to zero

module machine_dff #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  // Load d when enabled; clear immediately on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/machine_pd_history.sv
// rtl/machine_pd_history.sv - serial history shift register with saturating fill count

module machine_pd_history
  import machine_pkg::*;
#(
  parameter  int N   = 4,
  localparam int S_W = s_w(N)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           en_i,
  input  logic           x_i,
  input  logic           clr_fill_i,
  output logic [N-1:0]   hist_o,
  output logic [S_W-1:0] s_o,
  output logic [N-1:0]   hist_nxt_o,
  output logic [S_W-1:0] s_nxt_o
);

  logic [S_W-1:0] s_d;

  // Post-shift values are exported so the compare sees the bit being sampled this edge;
  // s_nxt_o deliberately ignores clr_fill_i to keep the match path acyclic.
  assign hist_nxt_o = {hist_o[N-2:0], x_i};
  assign s_nxt_o    = (s_o == S_W'(N)) ? s_o : s_o + S_W'(1);
  assign s_d        = clr_fill_i ? '0 : s_nxt_o;

  machine_dff #(.W(N)) u_hist_reg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_i),
    .d_i    (hist_nxt_o),
    .q_o    (hist_o)
  );

  machine_dff #(.W(S_W)) u_fill_reg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_i),
    .d_i    (s_d),
    .q_o    (s_o)
  );

endmodule

// File: rtl/machine_pattern_detect.sv
// rtl/machine_pattern_detect.sv - programmable N-bit serial pattern detector with match counter

module machine_pattern_detect
  import machine_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int CNT_W = 8,
  localparam int S_W   = s_w(N)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             x,
  input  logic [N-1:0]     PATTERN,
  input  logic             OVERLAP,
  input  logic             CLR_CNT,
  output logic             F,
  output logic [S_W-1:0]   S,
  output logic [N-1:0]     HIST,
  output logic [CNT_W-1:0] COUNT,
  output logic             SAT
);

  `MACHINE_RANGE_CHECK(g_chk_n, N, 2, 16)
  `MACHINE_RANGE_CHECK(g_chk_cnt_w, CNT_W, 1, 16)

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(cnt_max(CNT_W));

  logic [N-1:0]     hist_nxt;
  logic [S_W-1:0]   s_nxt;
  logic             match;
  logic             f_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             sat_q;

  // A match needs a full window of fresh bits equal to the current pattern.
  assign match = EN && (s_nxt == S_W'(N)) && (hist_nxt == PATTERN);

  machine_pd_history #(.N(N)) u_history (
    .clk_i      (CLK),
    .rst_ni     (RESET),
    .en_i       (EN),
    .x_i        (x),
    .clr_fill_i (match && !OVERLAP),
    .hist_o     (HIST),
    .s_o        (S),
    .hist_nxt_o (hist_nxt),
    .s_nxt_o    (s_nxt)
  );

  // Next match count: clear wins (keeping this edge's match), otherwise saturating increment.
  always_comb begin
    count_d = count_q;
    if (CLR_CNT) begin
      count_d = match ? CNT_W'(1) : '0;
    end else if (match && (count_q != CNT_TOP)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Register the match pulse, the count and its saturation flag together.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      f_q     <= 1'b0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      f_q     <= match;
      count_q <= count_d;
      sat_q   <= (count_d == CNT_TOP);
    end
  end

  assign F     = f_q;
  assign COUNT = count_q;
  assign SAT   = sat_q;

endmodule

// File: tb/tb_machine_pattern_detect.sv
// tb/tb_machine_pattern_detect.sv - self-checking bench for machine_pattern_detect

module tb_machine_pattern_detect;

  localparam int N     = 4;
  localparam int CNT_W = 2;
  localparam int S_W   = 3;
  localparam int CMAX  = 3;

  logic             CLK = 1'b0;
  logic             RESET = 1'b0;
  logic             EN = 1'b0;
  logic             x = 1'b0;
  logic [N-1:0]     PATTERN = '0;
  logic             OVERLAP = 1'b0;
  logic             CLR_CNT = 1'b0;
  logic             F;
  logic [S_W-1:0]   S;
  logic [N-1:0]     HIST;
  logic [CNT_W-1:0] COUNT;
  logic             SAT;

  machine_pattern_detect #(.N(N), .CNT_W(CNT_W)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .EN      (EN),
    .x       (x),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP),
    .CLR_CNT (CLR_CNT),
    .F       (F),
    .S       (S),
    .HIST    (HIST),
    .COUNT   (COUNT),
    .SAT     (SAT)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: all bits seen since reset, and bits collected since the last fresh start.
  bit seen[$];
  int fresh;
  int m_f;
  int m_count;

  function automatic int model_hist();
    int h = 0;
    for (int i = 0; i < N; i++) begin
      if (seen.size() > i) h = h | (int'(seen[seen.size() - 1 - i]) << i);
    end
    return h;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    logic [31:0] e;
    e = exp;
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".F"},     32'(F),     m_f);
    chk({tag, ".S"},     32'(S),     (fresh > N) ? N : fresh);
    chk({tag, ".HIST"},  32'(HIST),  model_hist());
    chk({tag, ".COUNT"}, 32'(COUNT), m_count);
    chk({tag, ".SAT"},   32'(SAT),   (m_count == CMAX) ? 1 : 0);
  endtask

  task automatic model_reset();
    seen.delete();
    fresh   = 0;
    m_f     = 0;
    m_count = 0;
  endtask

  // One clock edge with the given inputs, then model update and full check.
  task automatic step(input string tag, input bit en_v, input bit x_v, input bit clr_v = 1'b0);
    int match;
    EN = en_v;
    x = x_v;
    CLR_CNT = clr_v;
    @(posedge CLK);
    #1;
    match = 0;
    if (en_v) begin
      seen.push_back(x_v);
      fresh++;
      if (fresh >= N && model_hist() == int'(PATTERN)) begin
        match = 1;
        if (!OVERLAP) fresh = 0;
      end
    end
    m_f = match;
    if (clr_v) m_count = match;
    else if (match != 0 && m_count < CMAX) m_count++;
    check_all(tag);
  endtask

  // Async reset pulse starting mid-cycle; outputs must clear before any edge.
  task automatic do_reset(input string tag);
    #2;
    RESET = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset");
    @(posedge CLK);
    #1;
    RESET = 1'b1;

    PATTERN = 4'b1011; OVERLAP = 1'b1;
    step("t1", 1, 1); step("t1", 1, 0); step("t1", 1, 1); step("t1", 1, 1);
    chk("t1_F", 32'(F), 1);
    chk("t1_HIST", 32'(HIST), 4'b1011);
    step("t1_after", 1, 0);
    chk("t1_F_drop", 32'(F), 0);

    do_reset("t2a_rst");
    PATTERN = 4'b1010; OVERLAP = 1'b1;
    for (int i = 0; i < 6; i++) step("t2a", 1, bit'((i + 1) % 2));
    chk("t2a_COUNT", 32'(COUNT), 2);

    do_reset("t2b_rst");
    OVERLAP = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step("t2b", 1, bit'((i + 1) % 2));
      if (i == 3) chk("t2b_S4", 32'(S), 0);
    end
    chk("t2b_S6", 32'(S), 2);
    chk("t2b_COUNT", 32'(COUNT), 1);

    do_reset("t3_rst");
    PATTERN = 4'b0011;
    step("t3", 1, 0); step("t3", 1, 1); step("t3", 1, 1);
    chk("t3_HIST", 32'(HIST), 4'b0011);
    chk("t3_S", 32'(S), 3);
    step("t3", 1, 1);
    chk("t3_F", 32'(F), 0);

    do_reset("t4_rst");
    PATTERN = 4'b1011; OVERLAP = 1'b1;
    step("t4", 1, 1); step("t4", 1, 0);
    for (int i = 0; i < 3; i++) step("t4_hold", 0, bit'(i % 2));
    step("t4", 1, 1); step("t4", 1, 1);
    chk("t4_F", 32'(F), 1);

    do_reset("t5_rst");
    PATTERN = 4'b1111; OVERLAP = 1'b1;
    for (int i = 0; i < 8; i++) step("t5", 1, 1);
    chk("t5_SAT", 32'(SAT), 1);
    step("t5_clr", 1, 1, 1);
    chk("t5_clr_COUNT", 32'(COUNT), 1);
    chk("t5_clr_SAT", 32'(SAT), 0);

    do_reset("t6_rst");
    PATTERN = 4'b1011;
    step("t6", 1, 1); step("t6", 1, 0); step("t6", 1, 1);
    do_reset("t6_mid");
    step("t6", 1, 1);
    chk("t6_nomatch", 32'(F), 0);
    step("t6", 1, 1); step("t6", 1, 0); step("t6", 1, 1); step("t6", 1, 1);
    chk("t6_F", 32'(F), 1);

    do_reset("rand_rst");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) PATTERN = N'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) OVERLAP = ~OVERLAP;
      if ($urandom_range(0, 79) == 0) do_reset("rand_rst");
      step("rand", ($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
